usb_rx_packet_decoder: RTL and testbench

- Sits directly upstream of the endpoint data buffer on the RX path.
- Consumes decoded serial bits: NRZI-decoded, bit-unstuffed, one bit per `shift_en` strobe.
- Frames SYNC/PID/payload/CRC16 and writes payload bytes into the buffer through `store_rx_packet_data`/`rx_packet_data`, with the CRC field stripped.
- Reports packet type, data-ready, transfer-active and error status to the protocol controller.

---
 rtl/usb_rx_packet_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_usb_rx_packet_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_decoder.sv
// usb_rx_packet_decoder: frames SYNC/PID/payload/CRC16 from decoded USB RX bits.
// Optional define RX_CRC_CHECK_EN enables the CRC16 residual check at eop.
module usb_rx_packet_decoder (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       shift_en,
   input  logic       d_bit,
   input  logic       eop,
   input  logic       clear,
   input  logic [6:0] buffer_occupancy,
   output logic [7:0] rx_packet_data,
   output logic       store_rx_packet_data,
   output logic [2:0] rx_packet,
   output logic       rx_data_ready,
   output logic       rx_transfer_active,
   output logic       rx_error
);
   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOPW, S_ERR
   } state_t;

   state_t     r_state, w_next;
   logic [6:0] r_sr;
   logic [2:0] r_cnt;
   logic [7:0] r_pipe0, r_pipe1;
   logic [1:0] r_pcnt;
   logic [6:0] r_nstored;
   logic       r_tok;
   logic [7:0] r_data;
   logic       r_store, r_ready, r_active, r_err;
   logic [2:0] r_pid;

   logic [7:0] w_byte;
   logic       w_bit, w_done;
   logic [2:0] w_pid_code;
   logic       w_err, w_store, w_push, w_ready_set, w_pid_acc, w_crc_ok;

   // eop beats shift_en: a bit arriving with eop is discarded
   assign w_bit  = shift_en & ~eop;
   assign w_done = w_bit & (r_cnt == 3'd7);
   assign w_byte = {d_bit, r_sr};

   always_comb begin
      w_pid_code = 3'd0;
      if (w_byte[7:4] == ~w_byte[3:0]) begin
         case (w_byte[3:0])
            4'h1:    w_pid_code = 3'd1;
            4'h9:    w_pid_code = 3'd2;
            4'h3:    w_pid_code = 3'd3;
            4'hB:    w_pid_code = 3'd4;
            4'h2:    w_pid_code = 3'd5;
            4'hA:    w_pid_code = 3'd6;
            default: w_pid_code = 3'd0;
         endcase
      end
   end

`ifdef RX_CRC_CHECK_EN
   logic [15:0] r_crc, w_crc_nxt;
   logic        w_fb;
   assign w_fb      = d_bit ^ r_crc[15];
   assign w_crc_nxt = {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h8005 : 16'h0000);
   assign w_crc_ok  = (r_crc == 16'h800D);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                            r_crc <= 16'hFFFF;
      else if (w_pid_acc)                    r_crc <= 16'hFFFF;
      else if (r_state == S_DATA && w_bit)   r_crc <= w_crc_nxt;
   end
`else
   assign w_crc_ok = 1'b1;
`endif

   always_comb begin
      w_next      = r_state;
      w_err       = 1'b0;
      w_store     = 1'b0;
      w_push      = 1'b0;
      w_ready_set = 1'b0;
      w_pid_acc   = 1'b0;
      unique case (r_state)
         S_IDLE: if (w_bit) w_next = S_SYNC;
         S_SYNC: begin
            if (eop) begin
               w_err = 1'b1; w_next = S_IDLE;
            end else if (w_done && w_byte == 8'h80) begin
               w_next = S_PID;
            end else if (w_done) begin
               w_err = 1'b1; w_next = S_ERR;
            end
         end
         S_PID: begin
            if (eop) begin
               w_err = 1'b1; w_next = S_IDLE;
            end else if (w_done && w_pid_code != 3'd0) begin
               w_pid_acc = 1'b1;
               if (w_pid_code == 3'd3 || w_pid_code == 3'd4)      w_next = S_DATA;
               else if (w_pid_code == 3'd1 || w_pid_code == 3'd2) w_next = S_TOKEN;
               else                                               w_next = S_EOPW;
            end else if (w_done) begin
               w_err = 1'b1; w_next = S_ERR;
            end
         end
         S_TOKEN: begin
            if (eop) begin
               w_err = 1'b1; w_next = S_IDLE;
            end else if (w_done && r_tok) begin
               w_next = S_EOPW;
            end
         end
         S_DATA: begin
            if (eop) begin
               w_next = S_IDLE;
               if (r_cnt == 3'd0 && r_pcnt == 2'd2 && w_crc_ok) w_ready_set = 1'b1;
               else                                            w_err = 1'b1;
            end else if (w_done) begin
               if (r_pcnt != 2'd2) begin
                  w_push = 1'b1;
               end else if (buffer_occupancy == 7'd64 || r_nstored == 7'd64) begin
                  w_err = 1'b1; w_next = S_ERR;
               end else begin
                  w_store = 1'b1; w_push = 1'b1;
               end
            end
         end
         S_EOPW: begin
            if (eop) begin
               w_next = S_IDLE;
            end else if (shift_en) begin
               w_err = 1'b1; w_next = S_ERR;
            end
         end
         S_ERR:   if (eop) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= S_IDLE;
         r_sr      <= 7'd0;
         r_cnt     <= 3'd0;
         r_pipe0   <= 8'd0;
         r_pipe1   <= 8'd0;
         r_pcnt    <= 2'd0;
         r_nstored <= 7'd0;
         r_tok     <= 1'b0;
         r_data    <= 8'd0;
         r_store   <= 1'b0;
         r_ready   <= 1'b0;
         r_active  <= 1'b0;
         r_err     <= 1'b0;
         r_pid     <= 3'd0;
      end else begin
         r_state  <= w_next;
         r_store  <= w_store;
         r_err    <= w_err;
         r_active <= (w_next != S_IDLE);
         if (w_next == S_IDLE) begin
            r_cnt <= 3'd0;
         end else if (w_bit) begin
            r_sr  <= w_byte[7:1];
            r_cnt <= r_cnt + 3'd1;
         end
         if (w_pid_acc)                      r_tok <= 1'b0;
         else if (r_state == S_TOKEN && w_done) r_tok <= 1'b1;
         if (w_pid_acc) begin
            r_pcnt    <= 2'd0;
            r_nstored <= 7'd0;
            r_pid     <= w_pid_code;
         end else if (w_push) begin
            if (r_pcnt == 2'd2) begin
               r_pipe0 <= r_pipe1;
               r_pipe1 <= w_byte;
            end else if (r_pcnt == 2'd1) begin
               r_pipe1 <= w_byte;
               r_pcnt  <= 2'd2;
            end else begin
               r_pipe0 <= w_byte;
               r_pcnt  <= 2'd1;
            end
         end
         if (w_store) begin
            r_data    <= r_pipe0;
            r_nstored <= r_nstored + 7'd1;
         end
         // clear has priority over a same-cycle set
         if (clear)            r_ready <= 1'b0;
         else if (w_ready_set) r_ready <= 1'b1;
         else if (w_pid_acc)   r_ready <= 1'b0;
      end
   end

   assign rx_packet_data       = r_data;
   assign store_rx_packet_data = r_store;
   assign rx_packet            = r_pid;
   assign rx_data_ready        = r_ready;
   assign rx_transfer_active   = r_active;
   assign rx_error             = r_err;
endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// tb_usb_rx_packet_decoder: directed and randomized packets checked against
// a payload/CRC reference model built from the packet framing rules.
module tb_usb_rx_packet_decoder;
   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       shift_en = 1'b0;
   logic       d_bit = 1'b0;
   logic       eop = 1'b0;
   logic       clear = 1'b0;
   logic [6:0] buffer_occupancy = 7'd0;
   logic [7:0] rx_packet_data;
   logic       store_rx_packet_data;
   logic [2:0] rx_packet;
   logic       rx_data_ready;
   logic       rx_transfer_active;
   logic       rx_error;

   int total = 0;
   int bad = 0;
   int err_seen = 0;
   logic gaps = 1'b0;
   byte unsigned got_q[$];

`ifdef RX_CRC_CHECK_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   usb_rx_packet_decoder dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .shift_en             (shift_en),
      .d_bit                (d_bit),
      .eop                  (eop),
      .clear                (clear),
      .buffer_occupancy     (buffer_occupancy),
      .rx_packet_data       (rx_packet_data),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_packet            (rx_packet),
      .rx_data_ready        (rx_data_ready),
      .rx_transfer_active   (rx_transfer_active),
      .rx_error             (rx_error)
   );

   always @(negedge clk) begin
      if (store_rx_packet_data) got_q.push_back(rx_packet_data);
      if (rx_error) err_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      if (gaps && $urandom_range(0, 3) == 0) begin
         shift_en = 1'b0;
         @(negedge clk);
      end
      shift_en = 1'b1;
      d_bit = b;
      @(negedge clk);
      shift_en = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 8; k++) send_bit(b[k]);
   endtask

   function automatic logic [15:0] crc_field(input byte unsigned p[$]);
      logic [15:0] c;
      logic [7:0]  v;
      logic        fb;
      c = 16'hFFFF;
      foreach (p[i]) begin
         v = p[i];
         for (int k = 0; k < 8; k++) begin
            fb = v[k] ^ c[15];
            c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      end
      return ~c;
   endfunction

   task automatic start_pkt();
      got_q.delete();
      err_seen = 0;
   endtask

   // SYNC, PID, payload, CRC field sent high-order CRC bit first
   task automatic send_data(input logic [7:0] pid, input byte unsigned p[$],
                            input int flip);
      logic [15:0] f;
      logic [7:0]  b0, b1;
      f = crc_field(p);
      for (int k = 0; k < 8; k++) begin
         b0[k] = f[15-k];
         b1[k] = f[7-k];
      end
      if (flip >= 0) b0 = b0 ^ (8'h01 << flip);
      send_byte(8'h80);
      send_byte(pid);
      foreach (p[i]) send_byte(p[i]);
      send_byte(b0);
      send_byte(b1);
   endtask

   task automatic finish_pkt(input string tag, input byte unsigned exp_q[$],
                             input logic exp_rdy, input int exp_err,
                             input logic [2:0] exp_pid);
      eop = 1'b1;
      @(negedge clk);
      eop = 1'b0;
      chk({tag, ".ready"}, rx_data_ready, exp_rdy);
      chk({tag, ".active"}, rx_transfer_active, 0);
      idle(2);
      chk({tag, ".nstore"}, got_q.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < got_q.size())
            chk($sformatf("%s.byte%0d", tag, i), got_q[i], exp_q[i]);
      chk({tag, ".err"}, err_seen, exp_err);
      chk({tag, ".pid"}, rx_packet, exp_pid);
   endtask

   byte unsigned pay[$];
   byte unsigned none[$];
   byte unsigned part[$];

   initial begin
      #2;
      chk("rst.data", rx_packet_data, 0);
      chk("rst.store", store_rx_packet_data, 0);
      chk("rst.pid", rx_packet, 0);
      chk("rst.ready", rx_data_ready, 0);
      chk("rst.active", rx_transfer_active, 0);
      chk("rst.err", rx_error, 0);
      idle(2);
      n_rst = 1'b1;
      idle(2);

      // empty DATA0 with literal zero CRC field
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      chk("d0.active", rx_transfer_active, 1);
      send_byte(8'h00);
      send_byte(8'h00);
      finish_pkt("d0", none, 1'b1, 0, 3'd3);

      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear.ready", rx_data_ready, 0);

      // DATA1 with 4 random payload bytes
      pay.delete();
      repeat (4) pay.push_back(8'($urandom));
      start_pkt();
      send_data(8'h4B, pay, -1);
      finish_pkt("d1", pay, 1'b1, 0, 3'd4);

      // same packet, one CRC bit flipped
      start_pkt();
      send_data(8'h4B, pay, int'($urandom_range(0, 7)));
      finish_pkt("crcbad", pay, !CRC_ON, CRC_ON ? 1 : 0, 3'd4);

      start_pkt();
      send_byte(8'h80);
      send_byte(8'hD2);
      finish_pkt("ack", none, 1'b0, 0, 3'd5);

      start_pkt();
      send_byte(8'h80);
      send_byte(8'hD3);
      finish_pkt("badpid", none, 1'b0, 1, 3'd5);

      start_pkt();
      send_byte(8'h81);
      finish_pkt("badsync", none, 1'b0, 1, 3'd5);

      // buffer full at the first store
      buffer_occupancy = 7'd64;
      start_pkt();
      pay.delete();
      repeat (3) pay.push_back(8'($urandom));
      send_data(8'hC3, pay, -1);
      finish_pkt("occ64", none, 1'b0, 1, 3'd3);
      buffer_occupancy = 7'd0;

      // 65 payload bytes: 64 stored, the 65th dropped
      pay.delete();
      repeat (65) pay.push_back(8'($urandom));
      part = pay[0:63];
      start_pkt();
      send_data(8'h4B, pay, -1);
      finish_pkt("ovf65", part, 1'b0, 1, 3'd4);

      // eop after 3 bits of the fourth data byte
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      send_byte(8'h5A);
      send_byte(8'hA5);
      send_byte(8'h3C);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      part.delete();
      part.push_back(8'h5A);
      finish_pkt("partial", part, 1'b0, 1, 3'd3);

      // randomized mix of data and token packets
      gaps = 1'b1;
      for (int n = 0; n < 8; n++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         start_pkt();
         if (kind == 2) begin
            logic in_tok;
            in_tok = 1'($urandom);
            send_byte(8'h80);
            send_byte(in_tok ? 8'h69 : 8'hE1);
            send_byte(8'($urandom));
            send_byte(8'($urandom));
            finish_pkt($sformatf("rnd%0d.tok", n), none, 1'b0, 0,
                       in_tok ? 3'd2 : 3'd1);
         end else begin
            pay.delete();
            repeat ($urandom_range(0, 9)) pay.push_back(8'($urandom));
            send_data(kind == 1 ? 8'h4B : 8'hC3, pay, -1);
            finish_pkt($sformatf("rnd%0d.data", n), pay, 1'b1, 0,
                       kind == 1 ? 3'd4 : 3'd3);
         end
      end
      gaps = 1'b0;

      // reset in the middle of a payload
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      repeat (3) send_byte(8'($urandom));
      send_bit(1'b1);
      send_bit(1'b1);
      shift_en = 1'b1;
      n_rst = 1'b0;
      #1;
      chk("mrst.data", rx_packet_data, 0);
      chk("mrst.store", store_rx_packet_data, 0);
      chk("mrst.pid", rx_packet, 0);
      chk("mrst.ready", rx_data_ready, 0);
      chk("mrst.err", rx_error, 0);
      chk("mrst.active", rx_transfer_active, 0);
      shift_en = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      chk("mrst.active2", rx_transfer_active, 0);
      chk("mrst.err2", rx_error, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
